bit_stream_tx: RTL and testbench

//  Serial bit-pattern transmitter: captures an 8-bit word and shifts it out MSB-first, one bit per
//  clk_2 cycle, optionally repeating the word. Its out_bit feeds the sequence detector input, so

---
 rtl/bit_stream_pkg.sv | 31 +++
 rtl/seg7_hex_decoder.sv | 32 +++
 rtl/bit_stream_tx.sv | 156 +++++++++++++++
 tb/tb_bit_stream_tx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bit_stream_pkg.sv
// Shared types and constants for the serial bit-pattern transmitter and its
// seven-segment progress display.
package bit_stream_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } tx_state_t;

    // Active-high segment codes, bit7 (decimal point) always off
    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;
    localparam logic [7:0] SEG_A = 8'h77;
    localparam logic [7:0] SEG_B = 8'h7C;
    localparam logic [7:0] SEG_C = 8'h39;
    localparam logic [7:0] SEG_D = 8'h5E;
    localparam logic [7:0] SEG_E = 8'h79;
    localparam logic [7:0] SEG_F = 8'h71;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit to seven-segment decoder, shared with the hex counter.
module seg7_hex_decoder
    import bit_stream_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_0;
        case (i_hex)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_0;
        endcase
    end

endmodule

// File: rtl/bit_stream_tx.sv
// Serial transmitter: sends a captured word MSB-first, optionally repeated with
// idle gaps, and counts bits that are the third-or-later 1 of a run.
module bit_stream_tx
    import bit_stream_pkg::*;
#(
    parameter int NBITS_WORD = 8,
    parameter int NBITS_REP  = 2,
    parameter int GAP_CYCLES = 1,
    parameter int NBITS_RUN  = 8
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [NBITS_WORD-1:0] data_in,
    input  logic [NBITS_REP-1:0]  repeat_cnt,
    output logic                  out_bit,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            bits_left,
    output logic [7:0]            SEG,
    output logic [NBITS_RUN-1:0]  run_count
);

    localparam int BL_W  = $clog2(NBITS_WORD) + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BL_W-1:0]      BL_FULL  = BL_W'(NBITS_WORD);
    localparam logic [BL_W-1:0]      BL_ONE   = BL_W'(1);
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]     GAP_ONE  = GAP_W'(1);
    localparam logic [NBITS_REP-1:0] REP_ONE  = NBITS_REP'(1);
    localparam logic [NBITS_RUN-1:0] RUN_ONE  = NBITS_RUN'(1);
    localparam logic [NBITS_RUN-1:0] RUN_MAX  = '1;

    tx_state_t             r_state;
    tx_state_t             w_next_state;
    logic                  r_start;
    logic                  r_start_q;
    logic [NBITS_WORD-1:0] r_shreg;
    logic [NBITS_WORD-1:0] r_hold;
    logic [NBITS_REP-1:0]  r_rep;
    logic [BL_W-1:0]       r_bits_left;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [1:0]            r_runlen;
    logic [NBITS_RUN-1:0]  r_run_count;
    logic                  w_start_edge;
    logic                  w_last_bit;
    logic                  w_bit;
    logic [3:0]            w_bits_left;

    // start is registered first, so a launch edge lands in LOAD one cycle later
    assign w_start_edge = r_start & ~r_start_q;
    assign w_last_bit   = (r_bits_left == BL_ONE);
    assign w_bit        = r_shreg[NBITS_WORD-1];

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_edge) w_next_state = LOAD;
            LOAD:    w_next_state = SHIFT;
            SHIFT:   if (w_last_bit) w_next_state = (r_rep != '0) ? GAP : DONE;
            GAP:     if (r_gap_cnt == GAP_LAST) w_next_state = SHIFT;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            IDLE:    busy = 1'b0;
            SHIFT:   out_valid = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign out_bit     = out_valid & w_bit;
    assign w_bits_left = 4'(r_bits_left);
    assign bits_left   = w_bits_left;
    assign run_count   = r_run_count;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_start     <= 1'b0;
            r_start_q   <= 1'b0;
            r_rep       <= '0;
            r_bits_left <= '0;
            r_gap_cnt   <= '0;
            r_runlen    <= '0;
            r_run_count <= '0;
        end else begin
            r_start   <= start;
            r_start_q <= r_start;
            case (r_state)
                LOAD: begin
                    r_rep       <= repeat_cnt;
                    r_run_count <= '0;
                    r_runlen    <= '0;
                    r_bits_left <= BL_FULL;
                end
                SHIFT: begin
                    r_bits_left <= r_bits_left - BL_ONE;
                    if (w_last_bit && (r_rep != '0)) begin
                        r_rep     <= r_rep - REP_ONE;
                        r_gap_cnt <= '0;
                    end
                    // runlen saturates at 3; only its ">=2" information matters
                    if (w_bit) begin
                        if (r_runlen != 2'd3) r_runlen <= r_runlen + 2'd1;
                        if ((r_runlen >= 2'd2) && (r_run_count != RUN_MAX))
                            r_run_count <= r_run_count + RUN_ONE;
                    end else begin
                        r_runlen <= '0;
                    end
                end
                GAP: begin
                    r_runlen  <= '0;
                    r_gap_cnt <= r_gap_cnt + GAP_ONE;
                    if (r_gap_cnt == GAP_LAST) r_bits_left <= BL_FULL;
                end
                default: ;
            endcase
        end
    end

    // Payload registers carry no reset; out_bit is gated by state
    always_ff @(posedge clk_2) begin
        case (r_state)
            LOAD: begin
                r_shreg <= data_in;
                r_hold  <= data_in;
            end
            SHIFT:   r_shreg <= {r_shreg[NBITS_WORD-2:0], 1'b0};
            GAP:     r_shreg <= r_hold;
            default: ;
        endcase
    end

    seg7_hex_decoder u_seg (
        .i_hex (w_bits_left),
        .o_seg (SEG)
    );

endmodule

// File: tb/tb_bit_stream_tx.sv
// Directed self-checking bench for bit_stream_tx with default parameters.
module tb_bit_stream_tx;

    logic       clk_2      = 1'b0;
    logic       reset_n    = 1'b1;
    logic       start      = 1'b0;
    logic [7:0] data_in    = 8'h00;
    logic [1:0] repeat_cnt = 2'd0;
    logic       out_bit;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [3:0] bits_left;
    logic [7:0] SEG;
    logic [7:0] run_count;

    int n_cmp = 0;
    int n_bad = 0;

    bit_stream_tx dut (
        .clk_2      (clk_2),
        .reset_n    (reset_n),
        .start      (start),
        .data_in    (data_in),
        .repeat_cnt (repeat_cnt),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .bits_left  (bits_left),
        .SEG        (SEG),
        .run_count  (run_count)
    );

    always #5 clk_2 = ~clk_2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    // Launches a transaction and checks every cycle through one cycle past done.
    task automatic do_txn(input string nm, input logic [7:0] w, input logic [1:0] r,
                          input logic [7:0] rc_prev, input logic [7:0] rc_exp);
        int   done_c;
        int   pos;
        logic ev;
        logic eb;
        done_c = 2 + (int'(r) + 1) * 8 + int'(r);
        data_in    = w;
        repeat_cnt = r;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("%s.busy_c0", nm), 32'(busy), 32'd0);
        for (int c = 1; c <= done_c + 1; c++) begin
            tick();
            ev  = 1'b0;
            pos = 0;
            if (c >= 2) begin
                pos = (c - 2) % 9;
                ev  = (pos < 8) && (((c - 2) / 9) <= int'(r));
            end
            eb = ev ? w[7 - pos] : 1'b0;
            chk($sformatf("%s.valid_c%0d", nm, c), 32'(out_valid), 32'(ev));
            chk($sformatf("%s.bit_c%0d", nm, c), 32'(out_bit), 32'(eb));
            chk($sformatf("%s.done_c%0d", nm, c), 32'(done), 32'(c == done_c));
            chk($sformatf("%s.busy_c%0d", nm, c), 32'(busy), 32'(c <= done_c));
            if (c == 1) chk($sformatf("%s.rc_load", nm), 32'(run_count), 32'(rc_prev));
            if (c == 2) chk($sformatf("%s.rc_clr", nm), 32'(run_count), 32'd0);
        end
        chk($sformatf("%s.run_count", nm), 32'(run_count), 32'(rc_exp));
    endtask

    initial begin
        logic [7:0] seg_exp [8];
        int ndone;
        seg_exp = '{8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06};

        // Power-up reset
        #1 reset_n = 1'b0;
        #2;
        chk("rst.out_bit", 32'(out_bit), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.bits_left", 32'(bits_left), 32'd0);
        chk("rst.SEG", 32'(SEG), 32'h3F);
        chk("rst.run_count", 32'(run_count), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // 0xE7 single word, then 0x00 clears run_count, then 0xFF repeated once
        do_txn("t1", 8'hE7, 2'd0, 8'd0, 8'd2);
        tick();
        do_txn("t6", 8'h00, 2'd0, 8'd2, 8'd0);
        tick();
        do_txn("t2", 8'hFF, 2'd1, 8'd0, 8'd12);
        tick();

        // Held start launches exactly one transaction
        data_in    = 8'h01;
        repeat_cnt = 2'd0;
        start      = 1'b1;
        ndone      = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) ndone++;
            if (c >= 1 && c <= 12)
                chk($sformatf("t3.bit_c%0d", c), 32'(out_bit), 32'(c == 9));
            if (c == 11) chk("t3.busy_after_done", 32'(busy), 32'd0);
        end
        chk("t3.busy_end", 32'(busy), 32'd0);
        chk("t3.done_pulses", 32'(ndone), 32'd1);
        chk("t3.run_count", 32'(run_count), 32'd0);
        start = 1'b0;
        tick();
        tick();

        // data_in change mid-word is ignored; bits_left/SEG progress
        data_in = 8'hAA;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int c = 2; c <= 9; c++) begin
            tick();
            if (c == 5) data_in = 8'h55;
            chk($sformatf("t4.bit_c%0d", c), 32'(out_bit), 32'((c % 2) == 0));
            chk($sformatf("t4.bits_left_c%0d", c), 32'(bits_left), 32'(10 - c));
            chk($sformatf("t4.SEG_c%0d", c), 32'(SEG), 32'(seg_exp[c - 2]));
        end
        tick();
        chk("t4.done", 32'(done), 32'd1);
        tick();
        chk("t4.bits_left_idle", 32'(bits_left), 32'd0);
        chk("t4.SEG_idle", 32'(SEG), 32'h3F);

        // Asynchronous reset in the middle of a word
        data_in = 8'hFF;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) tick();
        chk("t5.busy_pre", 32'(busy), 32'd1);
        chk("t5.bits_left_pre", 32'(bits_left), 32'd4);
        chk("t5.run_count_pre", 32'(run_count), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("t5.out_bit", 32'(out_bit), 32'd0);
        chk("t5.out_valid", 32'(out_valid), 32'd0);
        chk("t5.busy", 32'(busy), 32'd0);
        chk("t5.done", 32'(done), 32'd0);
        chk("t5.bits_left", 32'(bits_left), 32'd0);
        chk("t5.SEG", 32'(SEG), 32'h3F);
        chk("t5.run_count", 32'(run_count), 32'd0);
        tick();
        chk("t5.busy_held", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();
        do_txn("t5b", 8'h3C, 2'd0, 8'd0, 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
